// File: rtl/multiplier.sv
// rtl/multiplier.sv - sequential shift-add multiplier with signed and unsigned modes
//
// Purpose: produces the 2*WIDTH-bit product of a and b, taking one multiplier bit
// per clock. A signed operation multiplies magnitudes and then negates the
// product if the operand signs differ.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous, active-high
//   start      begin a multiply (sampled in IDLE only)
//   is_signed  1 = two's-complement operands, 0 = unsigned (sampled with start)
//   a, b       multiplicand / multiplier (sampled with start)
//   hi, lo     registered upper / lower half of the product
//   busy       high while the shift-add loop runs
//   done       one-cycle pulse when hi/lo hold the new result

module multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic               sign;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] product;

    // Negating the most negative value wraps back to itself, which read as
    // unsigned is exactly 2^(WIDTH-1), the correct magnitude.
    always_comb begin
        a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
        b_mag = (is_signed && b[WIDTH-1]) ? -b : b;
    end

    // One step: conditionally add into the upper half, keeping the carry as
    // bit WIDTH of the sum, then shift the whole accumulator right by one.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
        acc_step = {sum, acc[WIDTH-1:1]};
        product  = sign ? -acc_step : acc_step;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            sign   <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        acc    <= '0;
                        cnt    <= CW'(WIDTH - 1);
                    end
                end
                RUN: begin
                    acc    <= acc_step;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    // The last step's result goes straight to the outputs, so
                    // hi/lo stay untouched for the whole run.
                    if (cnt == '0) begin
                        {hi, lo} <= product;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 Parameter: WIDTH, 32, operand width in bits; SHALL be a power of two of at least 4.
REQ-002 Port: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 Port: is_signed  input  1  1 = two's-complement operands (mult), 0 = unsigned (multu); sampled with start.
REQ-006 Port: a  input  WIDTH  multiplicand; sampled with start.
REQ-007 Port: b  input  WIDTH  multiplier; sampled with start.
REQ-008 Port: hi  output  WIDTH  upper half of the 2*WIDTH product (registered).
REQ-009 Port: lo  output  WIDTH  lower half of the 2*WIDTH product (registered).
REQ-010 Port: busy  output  1  high while in RUN.
REQ-011 Port: done  output  1  one-cycle pulse; hi/lo are valid for the new operation.
REQ-012 The block SHALL use exactly one clock; reset SHALL be synchronous and active-high.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-014 IDLE: if start=1 at an edge (E0), the block SHALL latch is_signed, |a| and |b| (magnitudes when is_signed=1, raw values otherwise) plus sign = a[MSB]^b[MSB] (0 if unsigned), clear the 2*WIDTH accumulator, load the step counter with WIDTH-1, and enter RUN.
REQ-015 Magnitude of the most negative value (e.g. 0x80000000) SHALL be taken as the unsigned value 2^(WIDTH-1); no overflow flag exists.
REQ-016 RUN: each edge SHALL perform one shift-add step on one multiplier bit, LSB first: if the current bit is 1, add the multiplicand into the upper half of the accumulator with a carry bit; then shift the accumulator right by 1.
REQ-017 The step counter SHALL be $clog2(WIDTH) bits wide and decrement once per RUN edge; on the edge where it is 0 (edge E_WIDTH), the block SHALL enter DONE.
REQ-018 At edge E_WIDTH, {hi,lo} SHALL be loaded with the final product, two's-complement negated over all 2*WIDTH bits when sign=1.
REQ-019 hi/lo SHALL hold their previous values throughout RUN and SHALL change only at DONE entry or on reset.
REQ-020 DONE: done SHALL be 1 for exactly one cycle; the next edge SHALL return the FSM to IDLE unconditionally.
REQ-021 busy SHALL be 1 exactly in RUN, i.e. for WIDTH cycles (from E0 up to E_WIDTH); busy and done SHALL never both be 1.
REQ-022 start in RUN or DONE SHALL be ignored with no queuing; a new operation SHALL be accepted only in IDLE.
REQ-023 Operand inputs changing after E0 SHALL NOT affect the running operation.
REQ-024 Back-to-back operation: start held high SHALL produce one operation per WIDTH+2 cycles.

Reset
REQ-025 When reset=1 at an edge, the block SHALL enter IDLE and set hi=0, lo=0, busy=0, done=0, and clear the counter and accumulator.
REQ-026 Reset SHALL take priority over start and over every state transition, including an abort in mid-RUN with no done pulse.
REQ-027 After reset deasserts, a start in the first IDLE cycle SHALL be accepted.

Verification
REQ-028 Unsigned, a=7, b=6, start at E0: busy=1 for 32 cycles; at E32, done=1, hi=0x00000000, lo=0x0000002A; at E33, IDLE with done=0.
REQ-029 Unsigned, a=b=0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001.
REQ-030 Signed, a=0xFFFFFFFD (-3), b=5: hi=0xFFFFFFFF, lo=0xFFFFFFF1; signed, a=b=0x80000000: hi=0x40000000, lo=0x00000000.
REQ-031 Signed, a=0x80000000, b=0xFFFFFFFF: hi=0x00000000, lo=0x80000000; the same operands unsigned: hi=0x7FFFFFFF, lo=0x80000000.
REQ-032 Start pulse with new operands at RUN cycle 5: ignored, and the original result is delivered; reset at RUN cycle 10: busy=0 and hi=lo=0 next cycle, with no done pulse.
REQ-033 Start held high for 100 cycles with a=2, b=3: done pulses every 34 cycles with lo=6, and busy is never high together with done.
